trace_capture_buffer: RTL

TRACE_CAPTURE_BUFFER -- requirements
Module: trace_capture_buffer

---
 rtl/trace_capture_buffer_if.sv | 28 ++
 rtl/trace_capture_buffer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/trace_capture_buffer_if.sv
// Trace capture bus: incoming trace words plus the valid/ready read-out port.
interface trace_capture_buffer_if #(
    parameter int unsigned DATA_W = 36
);
    logic              trace_valid;
    logic [DATA_W-1:0] trace_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;

    // Environment side: produces trace words and consumes buffered words.
    modport master (
        output trace_valid,
        output trace_data,
        output rd_ready,
        input  rd_valid,
        input  rd_data
    );

    // Buffer side.
    modport slave (
        input  trace_valid,
        input  trace_data,
        input  rd_ready,
        output rd_valid,
        output rd_data
    );
endinterface

// File: rtl/trace_capture_buffer.sv
// Trace capture buffer: records qualified trace words after arm, freezes on trap
// (optionally after POST_TRIG further words), then drains oldest-first.
module trace_capture_buffer #(
    parameter int unsigned DATA_W    = 36,
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned MODE      = 0,
    parameter int unsigned POST_TRIG = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     arm,
    input  logic                     trap,
    trace_capture_buffer_if.slave    bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     busy,
    output logic                     done
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned PostLastInt = (POST_TRIG == 0) ? 0 : POST_TRIG - 1;
    localparam logic [CW-1:0] FullCount = CW'(DEPTH);
    localparam logic [CW-1:0] PostLast  = CW'(PostLastInt);

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StPost,
        StDrain
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   post_cnt_q, post_cnt_d;
    logic            overflow_q, overflow_d;
    logic            done_q, done_d;
    logic            mem_we;
    logic            rd_valid_w;
    logic            capturing;

    logic [DATA_W-1:0] mem_q [DEPTH];

    assign capturing  = (state_q == StCapture) || (state_q == StPost);
    assign rd_valid_w = (state_q == StDrain) && (count_q != '0);

    // Next-state, pointer, occupancy and status computation.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        post_cnt_d = post_cnt_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        mem_we     = 1'b0;

        // Word acceptance is shared by CAPTURE and POST.
        if (capturing && bus.trace_valid) begin
            if (count_q != FullCount) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + AW'(1);
                count_d  = count_q + CW'(1);
            end else if (MODE == 0) begin
                overflow_d = 1'b1;
            end else begin
                // Ring mode: the oldest entry sits at the write pointer when full.
                mem_we     = 1'b1;
                wr_ptr_d   = wr_ptr_q + AW'(1);
                rd_ptr_d   = rd_ptr_q + AW'(1);
                overflow_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
            end
            StCapture: begin
                if (trap) begin
                    post_cnt_d = '0;
                    state_d    = (POST_TRIG == 0) ? StDrain : StPost;
                end
            end
            StPost: begin
                // Dropped words count toward the post-trigger window too.
                if (bus.trace_valid) begin
                    post_cnt_d = post_cnt_q + CW'(1);
                    if (post_cnt_q == PostLast) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (count_q == '0) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else if (bus.rd_ready) begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    count_d  = count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Arm restarts capture from any non-draining state and discards this cycle's word.
        if (arm && (state_q != StDrain)) begin
            state_d    = StCapture;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            post_cnt_d = '0;
            overflow_d = 1'b0;
            mem_we     = 1'b0;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            post_cnt_q <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            post_cnt_q <= post_cnt_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    // Storage array; contents are only read once written, so no reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= bus.trace_data;
        end
    end

    // Read data is forced to zero outside valid so unwritten entries never leak.
    assign bus.rd_valid = rd_valid_w;
    assign bus.rd_data  = rd_valid_w ? mem_q[rd_ptr_q] : '0;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign busy         = (state_q != StIdle);
    assign done         = done_q;
endmodule
